// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin on ties, one IDLE cycle between grants,
// and a per-transfer ack timeout that aborts the owner with a single-cycle err pulse.
module wb_arbiter_2m #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,

    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [3:0]            m0_sel,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,

    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [3:0]            m1_sel,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,

    output logic                  core_cyc,
    output logic                  core_stb,
    output logic                  core_we,
    output logic [3:0]            core_sel,
    output logic [ADDR_WIDTH-1:0] core_addr,
    output logic [DATA_WIDTH-1:0] core_data_out,
    input  logic [DATA_WIDTH-1:0] core_data_in,
    input  logic                  core_ack,

    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [15:0] TIMEOUT_MAX = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic        last_owner;
    logic [15:0] wait_count;

    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic owner_cyc;
    logic timed_out;

    assign req0 = m0_cyc & m0_stb;
    assign req1 = m1_cyc & m1_stb;

    // Grants are masked by reset so a transfer caught by reset sees no ack or err.
    assign gnt0 = rst_n & (state == GRANT0);
    assign gnt1 = rst_n & (state == GRANT1);

    assign owner_cyc = (state == GRANT1) ? m1_cyc : m0_cyc;
    assign timed_out = (wait_count == TIMEOUT_MAX) & ~core_ack;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            wait_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_count <= '0;
                    if (req0 && (!req1 || last_owner)) begin
                        state <= GRANT0;
                    end else if (req1) begin
                        state <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (core_ack || !owner_cyc || wait_count == TIMEOUT_MAX) begin
                        state      <= IDLE;
                        last_owner <= (state == GRANT1);
                        wait_count <= '0;
                    end else begin
                        wait_count <= wait_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        core_cyc      = 1'b0;
        core_stb      = 1'b0;
        core_we       = 1'b0;
        core_sel      = '0;
        core_addr     = '0;
        core_data_out = '0;
        if (gnt0) begin
            core_cyc      = m0_cyc;
            core_stb      = m0_stb;
            core_we       = m0_we;
            core_sel      = m0_sel;
            core_addr     = m0_addr;
            core_data_out = m0_wdata;
        end else if (gnt1) begin
            core_cyc      = m1_cyc;
            core_stb      = m1_stb;
            core_we       = m1_we;
            core_sel      = m1_sel;
            core_addr     = m1_addr;
            core_data_out = m1_wdata;
        end
    end

    // An owner that has already dropped cyc is aborting, not timing out.
    assign m0_ack   = gnt0 & core_ack;
    assign m1_ack   = gnt1 & core_ack;
    assign m0_err   = gnt0 & m0_cyc & timed_out;
    assign m1_err   = gnt1 & m1_cyc & timed_out;
    assign m0_rdata = gnt0 ? core_data_in : '0;
    assign m1_rdata = gnt1 ? core_data_in : '0;
    assign busy     = gnt0 | gnt1;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: a per-cycle vector table for arbitration,
// abort and reset behaviour, plus hand-written timeout and timeout/ack-tie runs.
module tb_wb_arbiter_2m;

    localparam logic [31:0] M0_ADDR  = 32'h0000_0100;
    localparam logic [31:0] M1_ADDR  = 32'h0000_0200;
    localparam logic [31:0] M0_WDATA = 32'h0A0A_0A0A;
    localparam logic [31:0] M1_WDATA = 32'h1B1B_1B1B;
    localparam logic [3:0]  M0_SEL   = 4'h3;
    localparam logic [3:0]  M1_SEL   = 4'hF;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [3:0]  m0_sel;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [3:0]  m1_sel;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        core_cyc, core_stb, core_we, core_ack, busy;
    logic [3:0]  core_sel;
    logic [31:0] core_addr, core_data_out, core_data_in;

    int assertions = 0;
    int failures   = 0;

    always #5 sys_clk = ~sys_clk;

    wb_arbiter_2m #(
        .TIMEOUT_CYCLES(4),
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .m0_cyc       (m0_cyc),
        .m0_stb       (m0_stb),
        .m0_we        (m0_we),
        .m0_sel       (m0_sel),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_rdata     (m0_rdata),
        .m0_ack       (m0_ack),
        .m0_err       (m0_err),
        .m1_cyc       (m1_cyc),
        .m1_stb       (m1_stb),
        .m1_we        (m1_we),
        .m1_sel       (m1_sel),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_rdata     (m1_rdata),
        .m1_ack       (m1_ack),
        .m1_err       (m1_err),
        .core_cyc     (core_cyc),
        .core_stb     (core_stb),
        .core_we      (core_we),
        .core_sel     (core_sel),
        .core_addr    (core_addr),
        .core_data_out(core_data_out),
        .core_data_in (core_data_in),
        .core_ack     (core_ack),
        .busy         (busy)
    );

    // One record per clock cycle; owner: 0 = bus idle, 1 = m0 on bus, 2 = m1 on bus.
    typedef struct {
        logic        rst_n;
        logic [1:0]  cyc;
        logic        ack;
        logic [31:0] din;
        logic        busy;
        logic [1:0]  owner;
        logic [1:0]  acks;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [1:0] c, input logic a,
                                input logic [31:0] d, input logic b,
                                input logic [1:0] o, input logic [1:0] k);
        vec_t v;
        v.rst_n = r; v.cyc = c; v.ack = a; v.din = d;
        v.busy = b; v.owner = o; v.acks = k;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n        = v.rst_n;
        m0_cyc       = v.cyc[0];
        m0_stb       = v.cyc[0];
        m1_cyc       = v.cyc[1];
        m1_stb       = v.cyc[1];
        core_ack     = v.ack;
        core_data_in = v.din;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        logic        e_cyc;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr, e_wdata;
        string       tag;
        tag     = $sformatf("row%0d", idx);
        e_cyc   = (v.owner == 2'd1) ? v.cyc[0] : (v.owner == 2'd2) ? v.cyc[1] : 1'b0;
        e_we    = (v.owner == 2'd2);
        e_sel   = (v.owner == 2'd1) ? M0_SEL : (v.owner == 2'd2) ? M1_SEL : 4'h0;
        e_addr  = (v.owner == 2'd1) ? M0_ADDR : (v.owner == 2'd2) ? M1_ADDR : 32'h0;
        e_wdata = (v.owner == 2'd1) ? M0_WDATA : (v.owner == 2'd2) ? M1_WDATA : 32'h0;
        checkOutput({tag, " busy"},      32'(busy),     32'(v.busy));
        checkOutput({tag, " core_cyc"},  32'(core_cyc), 32'(e_cyc));
        checkOutput({tag, " core_stb"},  32'(core_stb), 32'(e_cyc));
        checkOutput({tag, " core_we"},   32'(core_we),  32'(e_we));
        checkOutput({tag, " core_sel"},  32'(core_sel), 32'(e_sel));
        checkOutput({tag, " core_addr"}, core_addr,     e_addr);
        checkOutput({tag, " core_dout"}, core_data_out, e_wdata);
        checkOutput({tag, " m0_ack"},    32'(m0_ack),   32'(v.acks[0]));
        checkOutput({tag, " m1_ack"},    32'(m1_ack),   32'(v.acks[1]));
        checkOutput({tag, " m0_err"},    32'(m0_err),   32'h0);
        checkOutput({tag, " m1_err"},    32'(m1_err),   32'h0);
        checkOutput({tag, " m0_rdata"},  m0_rdata, (v.owner == 2'd1) ? v.din : 32'h0);
        checkOutput({tag, " m1_rdata"},  m1_rdata, (v.owner == 2'd2) ? v.din : 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        core_ack = 1'b0; core_data_in = 32'h0;
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
    endtask

    // m1 write with a silent slave; optionally the slave acks exactly on the timeout cycle.
    task automatic run_timeout(input string name, input logic ack_on_timeout);
        int rise, err_cnt, err_at, ack_cnt, ack_at, end_at;
        logic busy_after;
        rise = -1; err_cnt = 0; err_at = -1; ack_cnt = 0; ack_at = -1; end_at = -1;
        busy_after = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1; core_ack = 1'b0; core_data_in = 32'h600D_F00D;
        for (int i = 0; i < 12; i++) begin
            core_ack = ack_on_timeout && rise >= 0 && i == rise + 4;
            @(negedge sys_clk);
            if (rise < 0 && core_stb) rise = i;
            if (m1_err) begin err_cnt++; if (err_at < 0) err_at = i; end
            if (m1_ack) begin ack_cnt++; if (ack_at < 0) ack_at = i; end
            if (m0_ack || m0_err) checkOutput({name, " m0 untouched"}, 32'(m0_ack | m0_err), 32'h0);
            if (end_at >= 0 && i == end_at + 1) busy_after = busy;
            if (end_at < 0 && (err_at >= 0 || ack_at >= 0)) end_at = i;
            @(posedge sys_clk); #1;
            if (end_at >= 0) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
        end
        core_ack = 1'b0;
        checkOutput({name, " stb latency"}, 32'(rise), 32'd1);
        if (ack_on_timeout) begin
            checkOutput({name, " ack count"}, 32'(ack_cnt), 32'd1);
            checkOutput({name, " ack cycle"}, 32'(ack_at), 32'd5);
            checkOutput({name, " err count"}, 32'(err_cnt), 32'd0);
        end else begin
            checkOutput({name, " err count"}, 32'(err_cnt), 32'd1);
            checkOutput({name, " err cycle"}, 32'(err_at), 32'd5);
            checkOutput({name, " ack count"}, 32'(ack_cnt), 32'd0);
        end
        checkOutput({name, " busy after end"}, 32'(busy_after), 32'd0);
    endtask

    initial begin
        m0_we = 1'b0; m0_sel = M0_SEL; m0_addr = M0_ADDR; m0_wdata = M0_WDATA;
        m1_we = 1'b1; m1_sel = M1_SEL; m1_addr = M1_ADDR; m1_wdata = M1_WDATA;

        //           rst  cyc   ack  din           busy own  acks
        vecs.push_back(mk(0, 2'b00, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(0, 2'b00, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0,        1, 1, 2'b00));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0,        1, 1, 2'b00));
        vecs.push_back(mk(1, 2'b01, 1, 32'hDEADBEEF, 1, 1, 2'b01));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(0, 2'b00, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 1, 2'b00));
        vecs.push_back(mk(1, 2'b11, 1, 32'hA0A0_0000,1, 1, 2'b01));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 2, 2'b00));
        vecs.push_back(mk(1, 2'b11, 1, 32'hB1B1_0000,1, 2, 2'b10));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 1, 2'b00));
        vecs.push_back(mk(1, 2'b11, 1, 32'hC0C0_0000,1, 1, 2'b01));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 2, 2'b00));
        vecs.push_back(mk(1, 2'b11, 1, 32'hD1D1_0000,1, 2, 2'b10));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b00, 1, 32'h0000_00FF,0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 1, 2'b00));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0,        1, 1, 2'b00));
        vecs.push_back(mk(1, 2'b10, 1, 32'h0000_005A,0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0,        1, 2, 2'b00));
        vecs.push_back(mk(1, 2'b10, 1, 32'hE1E1_0000,1, 2, 2'b10));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b01, 1, 32'h0000_1111,1, 1, 2'b01));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0,        0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0,        1, 1, 2'b00));
        vecs.push_back(mk(0, 2'b01, 1, 32'h0000_2222,0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b11, 1, 32'h0000_3333,0, 0, 2'b00));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 1, 2'b00));
        vecs.push_back(mk(1, 2'b11, 1, 32'h0000_4444,1, 1, 2'b01));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 0, 2'b00));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge sys_clk);
            checkVector(i, vecs[i]);
            @(posedge sys_clk); #1;
        end

        do_reset();
        run_timeout("timeout", 1'b0);
        run_timeout("timeout_ack_tie", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum cycles a granted transfer waits for slave ack before abort (legal range 1..65535).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the address width of all ports.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning the data width of all ports.
REQ-004 SHALL have port sys_clk, input, 1, the single clock for the block.
REQ-005 SHALL have port rst_n, input, 1, a synchronous, active-low reset sampled on the rising edge of sys_clk.
REQ-006 SHALL have master-0 (data) ports: m0_cyc, m0_stb, m0_we (in, 1 each); m0_sel (in, 4); m0_addr (in, ADDR_WIDTH); m0_wdata (in, DATA_WIDTH); m0_rdata (out, DATA_WIDTH); m0_ack (out, 1); m0_err (out, 1).
REQ-007 SHALL have master-1 (instruction fetch) ports with the same names, directions and widths as REQ-006, using the m1_ prefix.
REQ-008 SHALL have slave-side ports: core_cyc, core_stb, core_we (out, 1 each); core_sel (out, 4); core_addr (out, ADDR_WIDTH); core_data_out (out, DATA_WIDTH); core_data_in (in, DATA_WIDTH); core_ack (in, 1).
REQ-009 SHALL have port busy, output, 1, asserted when a grant is held.

Function
REQ-010 A request from master N SHALL be defined as mN_cyc & mN_stb.
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT0 and GRANT1.
REQ-012 In IDLE with a single requester, the FSM SHALL grant that requester on the next edge.
REQ-013 In IDLE with both masters requesting, the FSM SHALL grant the master that did not own the last completed grant (round-robin); after reset, master 0 wins the first tie.
REQ-014 While in GRANTn, the core_* outputs SHALL be driven combinationally from master n's inputs; in IDLE, core_cyc, core_stb, core_we and core_sel SHALL be 0, and core_addr and core_data_out SHALL be 0.
REQ-015 Request-to-bus latency SHALL be 1 cycle (request sampled in IDLE, core_stb high the following cycle).
REQ-016 While in GRANTn, mN_ack SHALL equal core_ack and mN_rdata SHALL equal core_data_in, both combinationally.
REQ-017 The non-granted master SHALL see ack=0, err=0 and rdata=0.
REQ-018 When core_ack=1 in GRANTn, the FSM SHALL go to IDLE on the next edge, with last-owner := n and the timeout counter cleared.
REQ-019 There SHALL be no back-to-back grant: at least one IDLE cycle separates transfers.
REQ-020 If the owner drops mN_cyc before ack, the FSM SHALL return to IDLE next cycle with no ack, no err, and last-owner := n.
REQ-021 A 16-bit timeout counter SHALL increment each GRANT cycle without ack, saturating at TIMEOUT_CYCLES.
REQ-022 When the counter equals TIMEOUT_CYCLES and core_ack=0, the block SHALL pulse mN_err=1 for exactly that one cycle and go to IDLE next edge, with the counter cleared and last-owner := n.
REQ-023 If core_ack=1 on the timeout cycle, ack SHALL win and err SHALL stay 0.
REQ-024 core_ack arriving while in IDLE SHALL be ignored: no ack to either master and no state change.
REQ-025 busy SHALL be 1 exactly in GRANT0 and GRANT1.

Reset
REQ-026 On a sys_clk edge with rst_n=0, the block SHALL enter IDLE, set last-owner := 1 (so master 0 wins the first tie), clear the counter, and drive all outputs to 0 in that cycle and the next.
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer with no ack and no err to either master; a core_ack arriving after reset SHALL be ignored per REQ-024.

Verification
REQ-028 Reset then single read: m0 requests with addr=0x0000_0100; slave acks after 2 cycles with data 0xDEADBEEF -> core_stb high at cycle 1, m0_ack=1 with m0_rdata=0xDEADBEEF, IDLE the next cycle.
REQ-029 Simultaneous requests, 4 transfers, slave ack latency 1 -> grant order m0, m1, m0, m1, with one IDLE cycle between transfers.
REQ-030 Timeout: TIMEOUT_CYCLES=4, m1 write, slave never acks -> m1_err pulses exactly once, 4 cycles after core_stb rises; m1_ack stays 0; busy falls the next cycle.
REQ-031 Timeout/ack tie: ack arrives on the timeout cycle -> m1_ack=1 and m1_err=0.
REQ-032 Abort: m0 drops cyc mid-wait -> IDLE next cycle; a late core_ack yields no ack to either master; a pending m1 request is then granted.
REQ-033 Reset mid-transfer: rst_n=0 for 1 cycle during GRANT0 -> all outputs 0; after release, a simultaneous request grants m0 first.
